popcount_frame_acc: RTL
=======================

Name: popcount_frame_acc

Overview:
- Sequential stage directly downstream of the 4-input ones counter.
- Accepts a stream of 4-bit nibbles over a valid/ready handshake and reduces each nibble to its ones count (0..4) through the 4-input counting cell.
- Accumulates those counts over a frame and presents the frame total on a valid/ready output.
- Feeds the parity/weight checkers that consume per-frame bit weights.

Parameters:
- FRAME_LEN, 16, maximum nibbles per frame (>=2); frame closes at this count unless in_last closes it earlier.
- CNT_W, 7, width of out_count; must satisfy 2^CNT_W > 4*FRAME_LEN.
- IDX_W, 4, width of nibble index and out_nibs; must satisfy 2^IDX_W >= FRAME_LEN.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_nib/in_last valid.
- in_ready  output  1  block can accept a nibble this cycle.
- in_nib  input  4  data nibble.
- in_last  input  1  nibble is the final one of the frame (early close).
- out_valid  output  1  out_count/out_nibs valid.
- out_ready  input  1  consumer accepts the result.
- out_count  output  CNT_W  total ones in the frame.
- out_nibs  output  IDX_W  nibbles in frame minus 1 (0 means 1 nibble).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; asserting it clears all state immediately regardless of clk.
- Reset values: state=IDLE, accumulator=0, index=0, out_valid=0, out_count=0, out_nibs=0, in_ready=1 once rst deasserts.
- Accept: a nibble is accepted on a rising edge where in_valid && in_ready.
- Ones count: the ones count of in_nib comes combinationally from the nib_popcnt sub-module. {c1,c0,s} forms a 3-bit value 0..4, zero-extended to CNT_W.
- in_ready: combinational from state only; 1 in IDLE and ACC, 0 in HOLD. No dependency on out_ready (no bypass).
- IDLE:
  - Accept and not closing -> acc = pc, idx = 1, go ACC.
  - Accept with closing -> go HOLD.
- ACC:
  - Accept and not closing -> acc += pc, idx += 1.
  - Accept with closing -> go HOLD.
  - No accept -> hold all state; in_valid gaps of any length are legal.
- Closing condition: in_last=1, or idx == FRAME_LEN-1 at accept. in_last on the FRAME_LEN-th nibble behaves identically to the count-based close.
- On close:
  - out_count <= acc_prev + pc, where acc_prev=0 if closing from IDLE.
  - out_nibs <= idx_prev, where idx_prev=0 if closing from IDLE.
  - out_valid <= 1.
  - acc and idx clear.
- Latency: out_valid rises the cycle after the closing accept.
- HOLD:
  - out_count, out_nibs and out_valid are stable until out_ready=1 with out_valid=1.
  - On that edge, out_valid <= 0 and state <= IDLE; in_ready returns to 1 in the following cycle.
  - Minimum frame spacing is therefore one bubble cycle after the result is taken.
- Overflow: impossible by the parameter constraint. Accumulator width is CNT_W; addition is unsigned.
- Single-nibble frame: in_last on the first nibble gives out_count = pc, out_nibs = 0.
- in_last in HOLD: ignored, since no accept can occur.
- Reset mid-frame or mid-HOLD: partial accumulation is discarded and the pending result is dropped; out_valid falls immediately (async).
- X-safety: in_nib and in_last are don't-care when in_valid=0. Outputs never depend on unaccepted inputs.

Decomposition:
- Shared package popcnt_pkg:
  - State enum {IDLE, ACC, HOLD} (2-bit encoding).
  - Constant NIB_W=4.
  - Function for minimum CNT_W given FRAME_LEN, used in a parameter assertion.
- Sub-module nib_popcnt: combinational 4-input ones counter.
  - Inputs a, b, c, cin; outputs s, c0, c1.
  - Exactly the existing counting-cell interface, instanced once on in_nib[3:0].
- Everything else (FSM, accumulator, index counter, output register) stays in popcount_frame_acc.

Test Plan:
- Reset then full frame: 16 nibbles of 4'hF, in_valid held high, out_ready=1 -> out_valid one cycle after 16th accept; out_count=64, out_nibs=15. in_ready low for exactly one cycle (HOLD), plus one bubble cycle.
- Early close: nibbles 4'h1, 4'h3, 4'h7 with in_last on the third -> out_count=6, out_nibs=2.
- Single nibble: 4'hA with in_last -> out_count=2, out_nibs=0.
- Backpressure: close frame of 4'h5 x16 (out_count=32) with out_ready=0 for 10 cycles:
  - Outputs stable and in_ready=0 throughout; in_valid offered meanwhile is not accepted.
  - out_ready=1 -> out_valid drops next edge.
  - Next frame starts clean from 0.
- Gapped input: 4'h8, idle 5 cycles, 4'hC, idle 2 cycles, 4'h0 with in_last -> out_count=3, out_nibs=2; idle cycles do not advance idx.
- Reset mid-frame: 8 nibbles of 4'hF, async rst pulse between edges -> out_valid=0 and in_ready=1 immediately. Then 4'h1 with in_last -> out_count=1, out_nibs=0 (no residue).

Source files
------------

// File: rtl/popcnt_pkg.sv
// popcnt_pkg: shared state encoding, nibble width and sizing helper for the popcount frame accumulator.
package popcnt_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;
  function automatic int min_cnt_w(input int frame_len);
    return $clog2(NIB_W * frame_len + 1);
  endfunction
endpackage

// File: rtl/nib_popcnt.sv
// nib_popcnt: combinational 4-input ones counter; {c1,c0,s} is the number of set inputs (0..4).
module nib_popcnt (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic cin,
  output logic s,
  output logic c0,
  output logic c1
);
  assign {c1, c0, s} = 3'(a) + 3'(b) + 3'(c) + 3'(cin);
endmodule

// File: rtl/popcount_frame_acc.sv
// popcount_frame_acc: accumulates per-nibble ones counts over a frame and holds the total until consumed.
module popcount_frame_acc
  import popcnt_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 7,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NIB_W-1:0] in_nib,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [IDX_W-1:0] out_nibs
);
  if (FRAME_LEN < 2 || CNT_W < min_cnt_w(FRAME_LEN) || (1 << IDX_W) < FRAME_LEN) begin : g_param_err
    $error("popcount_frame_acc: FRAME_LEN/CNT_W/IDX_W out of range");
  end
  state_e           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d, out_count_q, out_count_d, pc;
  logic [IDX_W-1:0] idx_q, idx_d, out_nibs_q, out_nibs_d;
  logic             out_valid_q, out_valid_d, s, c0, c1, accept, closing;
  nib_popcnt u_cnt (
    .a  (in_nib[0]),
    .b  (in_nib[1]),
    .c  (in_nib[2]),
    .cin(in_nib[3]),
    .s  (s),
    .c0 (c0),
    .c1 (c1)
  );
  assign pc       = CNT_W'({c1, c0, s});
  assign in_ready = state_q != HOLD;
  assign accept   = in_valid && in_ready;
  assign closing  = in_last || idx_q == IDX_W'(FRAME_LEN - 1);
  // acc_q and idx_q are always zero in IDLE, so one datapath covers both frame-start and mid-frame accepts
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_count_d = out_count_q;
    out_nibs_d  = out_nibs_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      state_d     = closing ? HOLD : ACC;
      acc_d       = closing ? '0 : acc_q + pc;
      idx_d       = closing ? '0 : idx_q + IDX_W'(1);
      out_count_d = closing ? acc_q + pc : out_count_q;
      out_nibs_d  = closing ? idx_q : out_nibs_q;
      out_valid_d = closing ? 1'b1 : out_valid_q;
    end
    if (state_q == HOLD && out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      out_count_q <= '0;
      out_nibs_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_count_q <= out_count_d;
      out_nibs_q  <= out_nibs_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_count = out_count_q;
  assign out_nibs  = out_nibs_q;
  assign out_valid = out_valid_q;
endmodule
